// File: rtl/gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gate_op_arbiter
// Description : Round-robin front end sharing one registered 7-function logic
//               unit between two valid/ready requesters (accept/exec/respond).
// Revision    : 1.0 - initial release
// ============================================================================
module gate_op_arbiter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [2:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [2:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         rsp_err,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] c_op_and  = 3'd0;
   localparam logic [2:0] c_op_or   = 3'd1;
   localparam logic [2:0] c_op_not  = 3'd2;
   localparam logic [2:0] c_op_nand = 3'd3;
   localparam logic [2:0] c_op_nor  = 3'd4;
   localparam logic [2:0] c_op_xor  = 3'd5;
   localparam logic [2:0] c_op_xnor = 3'd6;

   state_t       r_state;
   state_t       w_state_nxt;
   logic         r_run;
   logic         r_last_grant;
   logic [2:0]   r_op;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic         r_id;
   logic [W-1:0] r_rsp_data;
   logic         r_rsp_err;
   logic         r_rsp_id;

   logic         w_idle;
   logic         w_grant0;
   logic         w_grant1;
   logic         w_accept;
   logic         w_rsp_fire;
   logic [W-1:0] w_result;
   logic         w_err;

   // r_run keeps both readies low while reset is held and for one cycle after.
   always_comb begin
      w_idle     = (r_state == S_IDLE);
      w_grant0   = w_idle & r_run & req0_valid & (~req1_valid | r_last_grant);
      w_grant1   = w_idle & r_run & req1_valid & (~req0_valid | ~r_last_grant);
      w_accept   = w_grant0 | w_grant1;
      w_rsp_fire = (r_state == S_RESP) & rsp_ready;
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE:  w_state_nxt = w_accept ? S_EXEC : S_IDLE;
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = w_rsp_fire ? S_IDLE : S_RESP;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
      end
   end

   always_comb begin
      w_result = '0;
      w_err    = 1'b0;
      case (r_op)
         c_op_and:  w_result = r_a & r_b;
         c_op_or:   w_result = r_a | r_b;
         c_op_not:  w_result = ~r_a;
         c_op_nand: w_result = ~(r_a & r_b);
         c_op_nor:  w_result = ~(r_a | r_b);
         c_op_xor:  w_result = r_a ^ r_b;
         c_op_xnor: w_result = ~(r_a ^ r_b);
         default:   w_err    = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_id         <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_rsp_id     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op <= w_grant1 ? req1_op : req0_op;
            r_a  <= w_grant1 ? req1_a  : req0_a;
            r_b  <= w_grant1 ? req1_b  : req0_b;
            r_id <= w_grant1;
         end
         if (r_state == S_EXEC) begin
            r_rsp_data <= w_result;
            r_rsp_err  <= w_err;
            r_rsp_id   <= r_id;
         end
         // Priority flips only once the response has actually been consumed.
         if (w_rsp_fire) begin
            r_last_grant <= r_rsp_id;
         end
      end
   end

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_op_arbiter
// Description : Directed self-checking bench for gate_op_arbiter (W=8 and W=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_op_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   logic       r0_valid, r0_ready, r1_valid, r1_ready;
   logic [2:0] r0_op, r1_op;
   logic [7:0] r0_a, r0_b, r1_a, r1_b;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [7:0] rsp_data;

   logic       n0_valid, n0_ready, n1_valid, n1_ready;
   logic [2:0] n0_op, n1_op;
   logic [0:0] n0_a, n0_b, n1_a, n1_b;
   logic       n_rsp_valid, n_rsp_ready, n_rsp_id, n_rsp_err, n_busy;
   logic [0:0] n_rsp_data;

   int n_cmp = 0;
   int n_err = 0;

   gate_op_arbiter #(.W(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_op(r0_op), .req0_a(r0_a), .req0_b(r0_b),
      .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_op(r1_op), .req1_a(r1_a), .req1_b(r1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy)
   );

   gate_op_arbiter #(.W(1)) u_dut_w1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(n0_valid), .req0_ready(n0_ready), .req0_op(n0_op), .req0_a(n0_a), .req0_b(n0_b),
      .req1_valid(n1_valid), .req1_ready(n1_ready), .req1_op(n1_op), .req1_a(n1_a), .req1_b(n1_b),
      .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_id(n_rsp_id), .rsp_data(n_rsp_data),
      .rsp_err(n_rsp_err), .busy(n_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (id) begin
         r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
      end else begin
         r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
      end
   endtask

   // Waits (bounded) for the chosen ready, then steps past the accepting edge.
   task automatic wait_accept(input bit id, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((id ? r1_ready : r0_ready) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_accept"}, 32'(ok), 32'd1);
      if (ok) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_txn(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input bit exp_e, input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      drive_req(id, op, a, b);
      wait_accept(id, tag);
      if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
      check({tag, "_busy_exec"}, 32'(busy), 32'd1);
      check({tag, "_rv_exec"}, 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check({tag, "_rv"}, 32'(rsp_valid), 32'd1);
      check({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
      check({tag, "_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
      @(posedge clk); #1;
      check({tag, "_rv_done"}, 32'(rsp_valid), 32'd0);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
   endtask

   logic [7:0] exp_sweep [8];
   logic [3:0] tt [8];

   initial begin
      bit ok;
      bit winner;
      bit seen;
      exp_sweep = '{8'h88, 8'hEE, 8'h55, 8'h77, 8'h11, 8'h66, 8'h99, 8'h00};
      // bit index = {a,b}
      tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0000};

      rst_n = 1'b0;
      rsp_ready = 1'b0;
      r0_valid = 1'b1; r0_op = 3'd0; r0_a = 8'h00; r0_b = 8'h00;
      r1_valid = 1'b1; r1_op = 3'd0; r1_a = 8'h00; r1_b = 8'h00;
      n0_valid = 1'b0; n0_op = 3'd0; n0_a = 1'b0; n0_b = 1'b0;
      n1_valid = 1'b0; n1_op = 3'd0; n1_a = 1'b0; n1_b = 1'b0;
      n_rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rv", 32'(rsp_valid), 32'd0);
      check("rst_data", 32'(rsp_data), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_rdy0", 32'(r0_ready), 32'd0);
      check("rst_rdy1", 32'(r1_ready), 32'd0);
      @(negedge clk);
      r0_valid = 1'b0; r1_valid = 1'b0;
      rst_n = 1'b1;

      // Basic AND transaction
      run_txn(1'b0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, "t1");

      // Opcode sweep, alternating requesters
      for (int op = 0; op < 8; op++)
         run_txn(op[0], 3'(op), 8'hAA, 8'hCC, exp_sweep[op], (op == 7), $sformatf("t2_op%0d", op));

      // Contention: last grant was requester 1, so 0 wins first
      run_txn(1'b1, 3'd1, 8'h01, 8'h02, 8'h03, 1'b0, "t3_pre");
      @(negedge clk);
      rsp_ready = 1'b1;
      drive_req(1'b0, 3'd0, 8'hF0, 8'h3C);
      drive_req(1'b1, 3'd5, 8'h0F, 8'hFF);
      for (int k = 0; k < 6; k++) begin
         ok = 1'b0;
         winner = 1'b0;
         for (int i = 0; i < 20; i++) begin
            #1;
            check("t3_mutex", 32'(r0_ready & r1_ready), 32'd0);
            if (r0_ready === 1'b1 || r1_ready === 1'b1) begin
               ok = 1'b1;
               winner = r1_ready;
               break;
            end
            @(negedge clk);
         end
         check($sformatf("t3_grant_seen%0d", k), 32'(ok), 32'd1);
         check($sformatf("t3_order%0d", k), 32'(winner), 32'(k % 2));
         @(posedge clk); #1;
         @(posedge clk); #1;
         check($sformatf("t3_rv%0d", k), 32'(rsp_valid), 32'd1);
         check($sformatf("t3_id%0d", k), 32'(rsp_id), 32'(k % 2));
         check($sformatf("t3_data%0d", k), 32'(rsp_data), (k % 2) ? 32'hF0 : 32'h30);
         @(negedge clk);
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge clk); #1;

      // Backpressure for 10 cycles with requester 1 waiting
      @(negedge clk);
      rsp_ready = 1'b0;
      drive_req(1'b0, 3'd1, 8'h12, 8'h34);
      wait_accept(1'b0, "t4");
      r0_valid = 1'b0;
      drive_req(1'b1, 3'd0, 8'hFF, 8'hFF);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         check("t4_rv", 32'(rsp_valid), 32'd1);
         check("t4_data", 32'(rsp_data), 32'h36);
         check("t4_id", 32'(rsp_id), 32'd0);
         check("t4_busy", 32'(busy), 32'd1);
         check("t4_rdy", 32'({r0_ready, r1_ready}), 32'd0);
         @(posedge clk); #1;
      end
      r1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_rv_done", 32'(rsp_valid), 32'd0);

      // Reset during EXEC; last grant is now 0, reset must restore req0 priority
      @(negedge clk);
      drive_req(1'b1, 3'd3, 8'hFF, 8'h0F);
      wait_accept(1'b1, "t5");
      r1_valid = 1'b0;
      drive_req(1'b0, 3'd0, 8'hF0, 8'h3C);
      rst_n = 1'b0;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_rv", 32'(rsp_valid), 32'd0);
      check("t5_data", 32'(rsp_data), 32'd0);
      check("t5_err", 32'(rsp_err), 32'd0);
      check("t5_rdy0", 32'(r0_ready), 32'd0);
      @(negedge clk);
      r0_valid = 1'b0;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      check("t5_no_rsp", 32'(seen), 32'd0);
      @(negedge clk);
      drive_req(1'b0, 3'd0, 8'hF0, 8'h3C);
      drive_req(1'b1, 3'd5, 8'h0F, 8'hFF);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (r0_ready === 1'b1 || r1_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("t5_grant_seen", 32'(ok), 32'd1);
      check("t5_rdy0_after", 32'(r0_ready), 32'd1);
      check("t5_rdy1_after", 32'(r1_ready), 32'd0);
      @(posedge clk); #1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge clk); #1;
      check("t5_id_after", 32'(rsp_id), 32'd0);
      check("t5_data_after", 32'(rsp_data), 32'h30);
      @(posedge clk); #1;

      // W=1 exhaustive truth tables
      for (int op = 0; op < 8; op++) begin
         for (int ab = 0; ab < 4; ab++) begin
            @(negedge clk);
            n0_valid = 1'b1;
            n0_op = 3'(op);
            n0_a = 1'(ab >> 1);
            n0_b = 1'(ab);
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
               #1;
               if (n0_ready === 1'b1) begin
                  ok = 1'b1;
                  break;
               end
               @(negedge clk);
            end
            check($sformatf("t6_accept_op%0d_ab%0d", op, ab), 32'(ok), 32'd1);
            @(posedge clk); #1;
            n0_valid = 1'b0;
            @(posedge clk); #1;
            check($sformatf("t6_rv_op%0d_ab%0d", op, ab), 32'(n_rsp_valid), 32'd1);
            check($sformatf("t6_data_op%0d_ab%0d", op, ab), 32'(n_rsp_data), 32'(tt[op][ab]));
            check($sformatf("t6_err_op%0d_ab%0d", op, ab), 32'(n_rsp_err), 32'(op == 7));
            @(posedge clk); #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
